// File: rtl/adder_tree_pipe_if.sv
// Operand/result bus for the pipelined adder tree: input beat channel plus result channel.
interface adder_tree_pipe_if #(
  parameter int DWIDTH = 32,
  parameter int NUM_IN = 16
);
  logic [NUM_IN*DWIDTH-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     sat_en;
  logic [DWIDTH-1:0]        out_data;
  logic                     out_ovf;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, sat_en, out_ready,
    input  in_ready, out_data, out_ovf, out_valid
  );

  modport slave (
    input  in_data, in_valid, sat_en, out_ready,
    output in_ready, out_data, out_ovf, out_valid
  );
endinterface

// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: one register level per tree level, global-stall flow control,
// saturate-or-wrap formatting folded into the final adder register.
module adder_tree_node #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   sum_o
);
  assign sum_o = {a_i[W-1], a_i} + {b_i[W-1], b_i};
endmodule

module adder_tree_pipe #(
  parameter int DWIDTH = 32,
  parameter int NUM_IN = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  adder_tree_pipe_if.slave bus
);
  localparam int LEVELS = $clog2(NUM_IN);
  localparam int NPAD   = 1 << LEVELS;
  localparam int SW     = DWIDTH + LEVELS;
  localparam int VW     = LEVELS + 1;

  logic              advance;
  logic [LEVELS:0]   vld_pipe_q;
  logic [LEVELS-1:0] sat_pipe_q;
  logic [SW-1:0]     sum_full;
  logic [DWIDTH-1:0] out_data_d, out_data_q;
  logic              out_ovf_d, out_ovf_q;

  // Whole pipe moves together; only a held result at the output can stop it.
  assign advance      = ~vld_pipe_q[LEVELS] | bus.out_ready;
  assign bus.in_ready = advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      sat_pipe_q <= '0;
    end else if (advance) begin
      vld_pipe_q <= VW'({vld_pipe_q, bus.in_valid});
      sat_pipe_q <= LEVELS'({sat_pipe_q, bus.sat_en});
    end
  end

  // Level l holds NPAD>>l partial sums, each DWIDTH+l bits wide; level 0 is the operand register.
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N = NPAD >> l;
    localparam int W = DWIDTH + l;
    logic [N-1:0][W-1:0] sum_d, sum_q;

    if (l == 0) begin : g_in
      for (genvar k = 0; k < N; k++) begin : g_op
        if (k < NUM_IN) begin : g_real
          assign sum_d[k] = bus.in_data[k*DWIDTH +: DWIDTH];
        end else begin : g_pad
          assign sum_d[k] = '0;
        end
      end
    end else begin : g_add
      for (genvar j = 0; j < N; j++) begin : g_node
        adder_tree_node #(.W(W-1)) u_node (
          .a_i  (g_lvl[l-1].sum_q[2*j]),
          .b_i  (g_lvl[l-1].sum_q[2*j+1]),
          .sum_o(sum_d[j])
        );
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       sum_q <= '0;
      else if (advance) sum_q <= sum_d;
    end
  end

  adder_tree_node #(.W(SW-1)) u_root (
    .a_i  (g_lvl[LEVELS-1].sum_q[0]),
    .b_i  (g_lvl[LEVELS-1].sum_q[1]),
    .sum_o(sum_full)
  );

  // Sum fits in DWIDTH iff all bits from the DWIDTH sign position upward agree.
  always_comb begin
    out_ovf_d  = ~(&sum_full[SW-1:DWIDTH-1] | ~|sum_full[SW-1:DWIDTH-1]);
    out_data_d = sum_full[DWIDTH-1:0];
    if (out_ovf_d && sat_pipe_q[LEVELS-1])
      out_data_d = sum_full[SW-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else if (advance) begin
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  assign bus.out_valid = vld_pipe_q[LEVELS];
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;
endmodule
